conf_bus_master: RTL and testbench

- Initiator side of the conf peripheral bus.
- Accepts single load/store requests from the CPU memory stage through a valid/ready handshake.
- Drives one conf bus transaction: conf_en, byte-lane conf_wen, conf_addr, lane-replicated conf_wdata.
- For loads, captures the responder's registered conf_rdata one cycle later, then returns a lane-extracted, sign/zero-extended result through a valid/ready response channel.

---
 rtl/conf_bus_master.sv | 163 ++++++++++++++++
 tb/tb_conf_bus_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conf_bus_master.sv
// conf_bus_master: initiator side of the conf peripheral bus.
// Takes one load/store at a time from the CPU memory stage, runs a single
// conf bus access and returns the lane-extracted, extended load result.
// Optional build macro: CONF_BUS_MASTER_ALIGN_CHK_EN (misaligned half/word
// requests are answered with resp_err and never reach the bus).
module conf_bus_master #(
  parameter int AW = 32,
  parameter int DW = 32  // fixed at 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [1:0]    req_size,
  input  logic          req_sign,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          conf_en,
  output logic [3:0]    conf_wen,
  output logic [AW-1:0] conf_addr,
  output logic [DW-1:0] conf_wdata,
  input  logic [DW-1:0] conf_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        is_wr;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  off_q;

  logic [3:0]    lane_wen;
  logic [DW-1:0] lane_wdata;
  logic [DW-1:0] load_data;
  logic          align_err;

  // Only IDLE listens to the request channel.
  assign req_ready = (state == IDLE);

  // Store lane enables and lane-replicated write data from the live request.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    lane_wen   = 4'b1111;
    lane_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        lane_wen   = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_wen   = 4'b0011 << {req_addr[1], 1'b0};
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of the responder data and extend it.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = conf_rdata[{off_q, 3'b000} +: 8];
    h = conf_rdata[{off_q[1], 4'b0000} +: 16];
    load_data = conf_rdata;
    case (size_q)
      2'd0:    load_data = {{24{sign_q & b[7]}}, b};
      2'd1:    load_data = {{16{sign_q & h[15]}}, h};
      default: ;
    endcase
  end

`ifdef CONF_BUS_MASTER_ALIGN_CHK_EN
  // Half needs addr[0]=0, word (and size 3) needs addr[1:0]=0.
  always_comb begin
    align_err = 1'b0;
    case (req_size)
      2'd0:    align_err = 1'b0;
      2'd1:    align_err = req_addr[0];
      default: align_err = (req_addr[1:0] != 2'b00);
    endcase
  end
`else
  // No alignment check: misaligned requests go out on the lane rules.
  assign align_err = 1'b0;
`endif

  // Transaction FSM; every conf_* and resp_* output is a register here.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state      <= IDLE;
      is_wr      <= 1'b0;
      size_q     <= 2'd0;
      sign_q     <= 1'b0;
      off_q      <= 2'd0;
      conf_en    <= 1'b0;
      conf_wen   <= 4'b0000;
      conf_addr  <= '0;
      conf_wdata <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (align_err) begin
              // Rejected without touching the bus.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              is_wr     <= req_wr;
              size_q    <= req_size;
              sign_q    <= req_sign;
              off_q     <= req_addr[1:0];
              conf_en   <= 1'b1;
              conf_addr <= req_addr;
              conf_wen  <= req_wr ? lane_wen : 4'b0000;
              // Loads leave the last write data on the bus untouched.
              if (req_wr) conf_wdata <= lane_wdata;
              resp_err  <= 1'b0;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          conf_en  <= 1'b0;
          conf_wen <= 4'b0000;
          if (is_wr) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Responder data is registered, so it is valid in this cycle.
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conf_bus_master.sv
// Directed bench for conf_bus_master. Inputs are driven and outputs are
// sampled on the falling edge; a registered responder model returns rd_value
// the cycle after a read strobe.
module tb_conf_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic [31:0] conf_rdata = 32'h0;

  logic [31:0] rd_value = 32'h0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conf_bus_master #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .conf_en    (conf_en),
    .conf_wen   (conf_wen),
    .conf_addr  (conf_addr),
    .conf_wdata (conf_wdata),
    .conf_rdata (conf_rdata)
  );

  // Registered responder: read data appears the cycle after conf_en.
  always @(posedge clk)
    conf_rdata <= (conf_en && conf_wen == 4'b0000) ? rd_value : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a request for one accepting edge, then drop req_valid.
  task automatic issue(input logic wr, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_wr    = wr;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
    req_sign = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_conf_en", conf_en, 0);
    check("rst_conf_wen", conf_wen, 0);
    check("rst_conf_addr", conf_addr, 0);
    check("rst_conf_wdata", conf_wdata, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);

    // Word store
    issue(1'b1, 2'd2, 1'b0, 32'hffff0000, 32'h12345678);
    check("ws_conf_en", conf_en, 1);
    check("ws_conf_wen", conf_wen, 4'hf);
    check("ws_conf_addr", conf_addr, 32'hffff0000);
    check("ws_conf_wdata", conf_wdata, 32'h12345678);
    check("ws_req_ready", req_ready, 0);
    check("ws_resp_valid_c1", resp_valid, 0);
    tick();
    check("ws_conf_en_drop", conf_en, 0);
    check("ws_resp_valid", resp_valid, 1);
    check("ws_resp_rdata", resp_rdata, 0);
    tick();
    check("ws_resp_done", resp_valid, 0);
    check("ws_req_ready_back", req_ready, 1);

    // Byte store to lane 2
    issue(1'b1, 2'd0, 1'b0, 32'hffff0002, 32'h000000ab);
    check("bs_conf_en", conf_en, 1);
    check("bs_conf_wen", conf_wen, 4'b0100);
    check("bs_conf_wdata", conf_wdata, 32'habababab);
    tick();
    check("bs_resp_valid", resp_valid, 1);
    tick();

    // Signed byte load from lane 3
    rd_value = 32'h80ffffff;
    issue(1'b0, 2'd0, 1'b1, 32'hffff0003, 32'h0);
    check("lb_conf_en", conf_en, 1);
    check("lb_conf_wen", conf_wen, 0);
    check("lb_conf_addr", conf_addr, 32'hffff0003);
    check("lb_wdata_held", conf_wdata, 32'habababab);
    tick();
    check("lb_wait_conf_en", conf_en, 0);
    check("lb_wait_resp_valid", resp_valid, 0);
    tick();
    check("lb_resp_valid", resp_valid, 1);
    check("lb_resp_rdata", resp_rdata, 32'hffffff80);
    tick();

    // Zero-extended upper half load
    rd_value = 32'h8001beef;
    issue(1'b0, 2'd1, 1'b0, 32'hffff0002, 32'h0);
    tick(); tick();
    check("lhu_resp_valid", resp_valid, 1);
    check("lhu_resp_rdata", resp_rdata, 32'h00008001);
    tick();

    // Response backpressure with the next request held on the channel
    rd_value   = 32'h11223344;
    resp_ready = 1'b0;
    req_valid  = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_sign = 1'b0;
    req_addr   = 32'hffff0004; req_wdata = 32'h0;
    tick();
    req_wr = 1'b1; req_size = 2'd0; req_addr = 32'hffff0001; req_wdata = 32'h0000005c;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_rdata", resp_rdata, 32'h11223344);
      check("bp_req_ready", req_ready, 0);
      check("bp_conf_en", conf_en, 0);
      if (i < 4) tick();
    end
    resp_ready = 1'b1;
    tick();
    check("bp_released_req_ready", req_ready, 1);
    check("bp_released_resp_valid", resp_valid, 0);
    tick();
    req_valid = 1'b0;
    check("bp_next_conf_en", conf_en, 1);
    check("bp_next_conf_wen", conf_wen, 4'b0010);
    check("bp_next_conf_addr", conf_addr, 32'hffff0001);
    check("bp_next_conf_wdata", conf_wdata, 32'h5c5c5c5c);
    tick(); tick();

    // Reset pulse while waiting for load data
    rd_value = 32'hdeadbeef;
    issue(1'b0, 2'd2, 1'b0, 32'hffff0008, 32'h0);
    tick();
    check("rw_wait_conf_en", conf_en, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_req_ready", req_ready, 1);
    check("rw_conf_en", conf_en, 0);
    for (int i = 0; i < 4; i++) begin
      check("rw_no_resp", resp_valid, 0);
      tick();
    end

    // Misaligned word load
    rd_value = 32'ha5a5a5a5;
    issue(1'b0, 2'd2, 1'b0, 32'hffff0001, 32'h0);
`ifdef CONF_BUS_MASTER_ALIGN_CHK_EN
    check("mis_conf_en", conf_en, 0);
    check("mis_resp_valid", resp_valid, 1);
    check("mis_resp_err", resp_err, 1);
    check("mis_resp_rdata", resp_rdata, 0);
    tick();
    check("mis_done", resp_valid, 0);
`else
    check("mis_conf_en", conf_en, 1);
    check("mis_conf_addr", conf_addr, 32'hffff0001);
    tick(); tick();
    check("mis_resp_valid", resp_valid, 1);
    check("mis_resp_err", resp_err, 0);
    check("mis_resp_rdata", resp_rdata, 32'ha5a5a5a5);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
